// File: rtl/password_guess_generator.sv
// rtl/password_guess_generator.sv - base-26 lowercase candidate enumerator feeding the MD5 encrypter
// Odometer of digits (d[0] = last character) with a configurable start letter and stride.
module password_guess_generator #(
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [2:0]   increment,
  input  logic [7:0]   startingPosition,
  input  logic         stop,
  input  logic         word_ready,
  output logic         word_valid,
  output logic [127:0] word_in,
  output logic [4:0]   word_in_width,
  output logic         exhausted,
  output logic [31:0]  count
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_FROZEN, S_DONE} state_t;

  state_t                    r_state;
  logic [MAX_LEN-1:0][4:0]   r_digit;
  logic [4:0]                r_len;
  logic [2:0]                r_stride;

  logic [MAX_LEN-1:0][4:0]   w_next_digit;
  logic [4:0]                w_next_len;
  logic                      w_overflow;
  logic [127:0]              w_next_word;
  logic [127:0]              w_reset_word;
  logic [MAX_LEN-1:0][4:0]   w_reset_digit;
  logic [4:0]                w_start_digit;
  logic [2:0]                w_start_stride;
  logic [5:0]                w_sum;
  logic [5:0]                w_add;
  logic                      w_carry;

  // Characters are appended most significant first, then the whole string is left-aligned.
  function automatic logic [127:0] pack_word(input logic [MAX_LEN-1:0][4:0] dig,
                                             input logic [4:0] len);
    logic [127:0] w;
    w = '0;
    for (int j = MAX_LEN - 1; j >= 0; j--) begin
      if (5'(j) < len) w = {w[119:0], 8'h61 + {3'b000, dig[j]}};
    end
    return w << (7'd8 * (7'd16 - {2'b00, len}));
  endfunction

  always_comb begin
    w_start_digit  = (startingPosition >= 8'h61 && startingPosition <= 8'h7a) ?
                     5'(startingPosition - 8'h61) : 5'd0;
    w_start_stride = (increment == 3'd0) ? 3'd1 : increment;
    w_reset_digit  = '0;
    w_reset_digit[0] = w_start_digit;
    w_reset_word   = {8'h61 + {3'b000, w_start_digit}, 120'd0};
  end

  // Stride enters at d[0]; only the L active digits take part in the carry chain.
  always_comb begin
    w_sum        = '0;
    w_add        = '0;
    w_carry      = 1'b0;
    w_next_digit = r_digit;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < r_len) begin
        w_add   = (i == 0) ? {3'b000, r_stride} : {5'b00000, w_carry};
        w_sum   = {1'b0, r_digit[i]} + w_add;
        w_carry = (w_sum >= 6'd26);
        w_next_digit[i] = w_carry ? 5'(w_sum - 6'd26) : w_sum[4:0];
      end
    end
    w_next_len = r_len;
    w_overflow = 1'b0;
    if (w_carry) begin
      if (r_len < 5'(MAX_LEN)) w_next_len = r_len + 5'd1;
      else                     w_overflow = 1'b1;
    end
    w_next_word = pack_word(w_next_digit, w_next_len);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_digit       <= w_reset_digit;
      r_len         <= 5'd1;
      r_stride      <= w_start_stride;
      word_valid    <= 1'b0;
      word_in       <= w_reset_word;
      word_in_width <= 5'd1;
      exhausted     <= 1'b0;
      count         <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (stop) begin
            r_state <= S_FROZEN;
          end else if (enable) begin
            r_state    <= S_PRESENT;
            word_valid <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (word_ready) begin
            count <= count + 32'd1;
            if (w_overflow) begin
              r_state    <= S_DONE;
              word_valid <= 1'b0;
              exhausted  <= 1'b1;
            end else begin
              r_digit       <= w_next_digit;
              r_len         <= w_next_len;
              word_in       <= w_next_word;
              word_in_width <= w_next_len;
              if (stop) begin
                r_state    <= S_FROZEN;
                word_valid <= 1'b0;
              end else if (!enable) begin
                r_state    <= S_IDLE;
                word_valid <= 1'b0;
              end
            end
          end else if (stop) begin
            r_state    <= S_FROZEN;
            word_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_guess_generator.sv
// tb/tb_password_guess_generator.sv - directed and randomized checks of password_guess_generator
// Reference model tracks each candidate as an integer value and a length.
module tb_password_guess_generator;

  logic         clk = 1'b0;
  logic         reset, enable, stop, word_ready;
  logic [2:0]   increment;
  logic [7:0]   startingPosition;
  logic         o_valid [2];
  logic [127:0] o_word  [2];
  logic [4:0]   o_width [2];
  logic         o_exh   [2];
  logic [31:0]  o_count [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  longint      m_val    [2];
  int          m_len    [2];
  int          m_stride [2];
  bit          m_valid  [2];
  bit          m_frozen [2];
  bit          m_done   [2];
  logic [31:0] m_count  [2];
  int          maxl     [2] = '{8, 2};

  always #5 clk = ~clk;

  password_guess_generator #(.MAX_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .increment(increment),
    .startingPosition(startingPosition), .stop(stop), .word_ready(word_ready),
    .word_valid(o_valid[0]), .word_in(o_word[0]), .word_in_width(o_width[0]),
    .exhausted(o_exh[0]), .count(o_count[0]));

  password_guess_generator #(.MAX_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .increment(increment),
    .startingPosition(startingPosition), .stop(stop), .word_ready(word_ready),
    .word_valid(o_valid[1]), .word_in(o_word[1]), .word_in_width(o_width[1]),
    .exhausted(o_exh[1]), .count(o_count[1]));

  function automatic longint pow26(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p = p * 26;
    return p;
  endfunction

  function automatic logic [127:0] expect_word(input longint val, input int len);
    logic [127:0] w = '0;
    longint v = val;
    for (int k = len - 1; k >= 0; k--) begin
      w[120 - 8*k +: 8] = 8'h61 + 8'(v % 26);
      v = v / 26;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    longint p, v;
    if (!reset) begin
      m_val[i]    = (startingPosition >= 8'h61 && startingPosition <= 8'h7a) ?
                    longint'(startingPosition - 8'h61) : 0;
      m_len[i]    = 1;
      m_stride[i] = (increment == 0) ? 1 : int'(increment);
      m_valid[i]  = 0;
      m_frozen[i] = 0;
      m_done[i]   = 0;
      m_count[i]  = 0;
    end else if (m_done[i] || m_frozen[i]) begin
    end else if (!m_valid[i]) begin
      if (stop) m_frozen[i] = 1;
      else if (enable) m_valid[i] = 1;
    end else if (word_ready) begin
      m_count[i] = m_count[i] + 1;
      p = pow26(m_len[i]);
      v = m_val[i] + m_stride[i];
      if (v >= p && m_len[i] == maxl[i]) begin
        m_done[i]  = 1;
        m_valid[i] = 0;
      end else begin
        if (v >= p) begin
          v = v - p;
          m_len[i]++;
        end
        m_val[i] = v;
        if (stop) begin
          m_frozen[i] = 1;
          m_valid[i]  = 0;
        end else if (!enable) begin
          m_valid[i] = 0;
        end
      end
    end else if (stop) begin
      m_frozen[i] = 1;
      m_valid[i]  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid[%0d]", i), 128'(o_valid[i]), 128'(m_valid[i]));
      chk($sformatf("exhausted[%0d]", i), 128'(o_exh[i]), 128'(m_done[i]));
      chk($sformatf("count[%0d]", i), 128'(o_count[i]), 128'(m_count[i]));
      if (!m_done[i]) begin
        chk($sformatf("word[%0d]", i), o_word[i], expect_word(m_val[i], m_len[i]));
        chk($sformatf("width[%0d]", i), 128'(o_width[i]), 128'(m_len[i]));
      end
    end
  endtask

  function automatic logic [127:0] w1(input logic [7:0] c);
    return {c, 120'd0};
  endfunction

  function automatic logic [127:0] w2(input logic [7:0] c0, input logic [7:0] c1);
    return {c0, c1, 112'd0};
  endfunction

  initial begin
    reset = 1'b0; enable = 1'b0; stop = 1'b0; word_ready = 1'b0;
    increment = 3'd1; startingPosition = 8'h61;

    tick();
    chk("reset_valid", 128'(o_valid[0]), 128'd0);
    chk("reset_word", o_word[0], w1(8'h61));
    chk("reset_width", 128'(o_width[0]), 128'd1);
    chk("reset_count", 128'(o_count[0]), 128'd0);
    chk("reset_exh", 128'(o_exh[0]), 128'd0);

    reset = 1'b1; enable = 1'b1; word_ready = 1'b1;
    repeat (27) tick();
    chk("aa_word", o_word[0], w2(8'h61, 8'h61));
    chk("aa_width", 128'(o_width[0]), 128'd2);
    chk("aa_count", 128'(o_count[0]), 128'd26);

    reset = 1'b0; enable = 1'b0; word_ready = 1'b0;
    tick();
    reset = 1'b1; enable = 1'b1;
    tick();
    word_ready = 1'b1;
    repeat (2) tick();
    word_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_word", o_word[0], w1(8'h63));
      chk("bp_valid", 128'(o_valid[0]), 128'd1);
      chk("bp_count", 128'(o_count[0]), 128'd2);
    end
    word_ready = 1'b1;
    tick();
    chk("bp_next_word", o_word[0], w1(8'h64));
    chk("bp_next_count", 128'(o_count[0]), 128'd3);

    repeat (7) tick();
    chk("k_word", o_word[0], w1(8'h6b));
    word_ready = 1'b0; stop = 1'b1;
    tick();
    chk("stop_valid", 128'(o_valid[0]), 128'd0);
    chk("stop_word", o_word[0], w1(8'h6b));
    chk("stop_count", 128'(o_count[0]), 128'd10);
    stop = 1'b0;
    repeat (10) begin
      enable = 1'($urandom); word_ready = 1'($urandom);
      tick();
    end
    chk("frozen_valid", 128'(o_valid[0]), 128'd0);
    chk("frozen_word", o_word[0], w1(8'h6b));
    chk("frozen_count", 128'(o_count[0]), 128'd10);

    reset = 1'b0; increment = 3'd3;
    tick();
    reset = 1'b1; enable = 1'b1; word_ready = 1'b1;
    repeat (10) tick();
    chk("inc3_word", o_word[0], w2(8'h61, 8'h62));
    chk("inc3_width", 128'(o_width[0]), 128'd2);
    chk("inc3_count", 128'(o_count[0]), 128'd9);

    reset = 1'b0; increment = 3'd0;
    tick();
    reset = 1'b1; increment = 3'd5;
    repeat (3) tick();
    chk("inc0_word", o_word[0], w1(8'h63));
    chk("inc0_count", 128'(o_count[0]), 128'd2);

    reset = 1'b0; increment = 3'd1;
    tick();
    reset = 1'b1;
    repeat (702) tick();
    chk("zz_word", o_word[1], w2(8'h7a, 8'h7a));
    chk("zz_valid", 128'(o_valid[1]), 128'd1);
    chk("zz_count", 128'(o_count[1]), 128'd701);
    tick();
    chk("done_valid", 128'(o_valid[1]), 128'd0);
    chk("done_exh", 128'(o_exh[1]), 128'd1);
    chk("done_count", 128'(o_count[1]), 128'd702);

    reset = 1'b0; startingPosition = 8'h6d;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("q_word", o_word[0], w1(8'h71));
    reset = 1'b0;
    tick();
    chk("midrst_valid", 128'(o_valid[0]), 128'd0);
    chk("midrst_word", o_word[0], w1(8'h6d));
    chk("midrst_width", 128'(o_width[0]), 128'd1);
    chk("midrst_count", 128'(o_count[0]), 128'd0);
    chk("midrst_exh", 128'(o_exh[1]), 128'd0);
    reset = 1'b1;
    tick();
    chk("m_present", o_word[0], w1(8'h6d));
    chk("m_valid", 128'(o_valid[0]), 128'd1);

    reset = 1'b0; startingPosition = 8'h5a;
    tick();
    chk("clamp_word", o_word[0], w1(8'h61));

    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 3) != 0);
      word_ready = ($urandom_range(0, 2) != 0);
      stop       = ($urandom_range(0, 199) == 0);
      increment  = 3'($urandom);
      startingPosition = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                         8'h61 + 8'($urandom_range(0, 25));
      reset      = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/password_guess_generator.md
# password_guess_generator

Upstream feeder for the MD5 brute-force controller: enumerates lowercase plaintext candidates (a..z, aa..zz, ...) as a base-26 odometer, starting at a configurable first letter and striding by a configurable increment so several controllers can partition the search space. Each candidate is presented left-aligned on a 128-bit word with its byte length, under a valid/ready handshake toward the MD5 encrypter input. Enumeration freezes on a match (`stop`) and reports exhaustion when candidates would exceed `MAX_LEN` characters.

## Interface
- `MAX_LEN`, 8: maximum candidate length in characters, 1..16.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `enable`  in  1  permits generation; drives the controller's `enable`.
- `increment`  in  3  stride per accepted candidate; 0 is treated as 1; sampled only while `reset`=0.
- `startingPosition`  in  8  ASCII first letter; outside 'a'..'z' is treated as 'a'; sampled only while `reset`=0.
- `stop`  in  1  match found (`hashes_equal`); freezes enumeration, sticky internally until reset.
- `word_ready`  in  1  encrypter ready to take a candidate.
- `word_valid`  out  1  `word_in` / `word_in_width` hold a valid candidate.
- `word_in`  out  128  candidate, first character in [127:120], unused low bytes zero.
- `word_in_width`  out  5  candidate length in bytes, 1..MAX_LEN.
- `exhausted`  out  1  sticky: search space for this stride finished.
- `count`  out  32  number of accepted candidates, wraps at 2^32.

## Operation
- State: digits d[0..MAX_LEN-1] (0..25, d[0] least significant = last character), length L, FSM IDLE / PRESENT / FROZEN / DONE.
- Reset (`reset`=0): d[0] = startingPosition-'a' (clamped), other digits 0, L=1, FSM IDLE, `word_valid`=0, `exhausted`=0, `count`=0, stop latch clear; `word_in` = packed reset candidate, `word_in_width`=1.
- IDLE: `enable`=1 -> PRESENT (`word_valid`=1). `stop`=1 -> FROZEN.
- PRESENT: outputs stable while `word_ready`=0. On `word_valid`&&`word_ready`: `count`+1, advance: d[0] += stride; per digit, value >=26 -> subtract 26, carry 1 into next digit. Carry out of d[L-1]: if L < MAX_LEN, L+1 and new top digit d[L]=0 ('a', carry not added); else -> DONE.
- After acceptance with `enable`=0 -> IDLE; else stays PRESENT with next candidate.
- An asserted `word_valid` is never withdrawn for `enable` dropping; only `stop`, exhaustion, or reset remove it.
- `stop`=1 in any state except DONE -> FROZEN: `word_valid`=0, digits/L/count hold; an acceptance in the same cycle as `stop` is counted and the digits advance, then freeze.
- DONE: `word_valid`=0, `exhausted`=1, state held until reset. FROZEN and DONE exit only by reset.
- Packing: character k (k=0 first/most significant) = 'a'+d[L-1-k] at word_in[127-8k -: 8]; bytes k >= L are 0x00.

## Timing
- All outputs registered; `word_in` and `word_in_width` are updated in the same edge as the digit advance.
- `word_valid` rises on the first edge at which `enable`=1 is sampled after reset release (1-cycle latency).
- Throughput: one candidate per cycle with `word_ready` held 1.
- `stop` sampled at edge N -> `word_valid`=0 after edge N.
- Exhaustion: final accept at edge N -> `word_valid`=0, `exhausted`=1 after edge N.
- Reset asserted mid-operation overrides everything at that edge, including a handshake in the same cycle (not counted).

## Test plan
- Reset, startingPosition='a', increment=1, enable=1, ready=1 -> a,b,...,z then "aa": word_in=0x6161 followed by 112 zero bits, width=2, count=26 at "aa" presentation.
- increment=3, start='a' -> a,d,g,...,y then "ab" (width 2); increment=0 behaves as 1.
- Backpressure: ready=0 for 5 cycles while "c" presented -> word_in/width/valid constant, count unchanged; ready=1 -> "d" next cycle.
- stop=1 while "k" presented -> valid=0 next cycle, word_in holds "k", count frozen; enable/ready toggling has no effect until reset.
- MAX_LEN=2, increment=1 -> last candidate "zz", count=702 after its accept, then valid=0, exhausted=1.
- Reset asserted mid-stream at "q" with start='m' -> next edge presents "m" at width 1, count=0, exhausted=0.
